// File: rtl/nios_system_tec1_led_pio_if.sv
// nios_system_tec1_led_pio_if: Avalon-MM slave bus bundle for the LED PIO
interface nios_system_tec1_led_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_tec1_led_pio.sv
// nios_system_tec1_led_pio: Avalon-MM LED output port with atomic set/clear and a hardware blink engine
module nios_system_tec1_led_pio #(
    parameter int                    DATA_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    DIV_WIDTH   = 24
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios_system_tec1_led_pio_if.slave     bus,
    output logic [DATA_WIDTH-1:0]         out_port
);
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic                  r_phase;
    logic [31:0]           r_readdata;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wd;
    logic [31:0]           w_rd_mux;
    assign w_wr = bus.chipselect && !bus.write_n;
    assign w_wd = bus.writedata[DATA_WIDTH-1:0];
    assign bus.readdata = r_readdata;
    assign out_port = r_data ^ (r_mask & {DATA_WIDTH{r_phase}});
    always_comb begin
        w_rd_mux = bus.address == 3'd0 ? 32'(r_data)  :
                   bus.address == 3'd1 ? 32'(r_mask)  :
                   bus.address == 3'd2 ? 32'(r_div)   :
                   bus.address == 3'd3 ? 32'(r_phase) : '0;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data     <= RESET_VALUE;
            r_mask     <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
            if (w_wr && bus.address == 3'd0)
                r_data <= w_wd;
            else if (w_wr && bus.address == 3'd4)
                r_data <= r_data | w_wd;
            else if (w_wr && bus.address == 3'd5)
                r_data <= r_data & ~w_wd;
            if (w_wr && bus.address == 3'd1)
                r_mask <= w_wd;
            // a DIV write restarts the blink period and wins over a terminal count
            if (w_wr && bus.address == 3'd2) begin
                r_div   <= bus.writedata[DIV_WIDTH-1:0];
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (r_cnt == r_div) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nios_system_tec1_led_pio.sv
// tb_nios_system_tec1_led_pio: directed bench with a behavioural register/blink model checked every cycle
module tb_nios_system_tec1_led_pio;
    localparam int          DW = 10;
    localparam logic [9:0]  RV = 10'h2A;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] out_port;
    int            errs = 0;
    int            checks = 0;
    nios_system_tec1_led_pio_if bus();
    nios_system_tec1_led_pio #(.DATA_WIDTH(DW), .RESET_VALUE(RV), .DIV_WIDTH(24)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port)
    );
    always #5 clk = ~clk;
    // model: phase is derived from edges elapsed since the last period restart
    longint        n = 0;
    longint        t0 = 0;
    logic [9:0]    m_data, m_mask;
    logic [23:0]   m_div;
    logic [31:0]   m_rd;
    bit            m_valid = 0;
    function automatic logic ph(input longint k);
        return 1'(((k - t0) / (longint'(m_div) + 1)) % 2);
    endfunction
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        if (!reset_n) begin
            m_data = RV; m_mask = '0; m_div = '0; m_rd = '0;
            n++;
            t0 = n;
            m_valid = 1;
        end else begin
            case (bus.address)
                3'd0: m_rd = {22'd0, m_data};
                3'd1: m_rd = {22'd0, m_mask};
                3'd2: m_rd = {8'd0, m_div};
                3'd3: m_rd = {31'd0, ph(n)};
                default: m_rd = '0;
            endcase
            n++;
            if (bus.chipselect && !bus.write_n) begin
                case (bus.address)
                    3'd0: m_data = bus.writedata[9:0];
                    3'd1: m_mask = bus.writedata[9:0];
                    3'd2: begin m_div = bus.writedata[23:0]; t0 = n; end
                    3'd4: m_data = m_data | bus.writedata[9:0];
                    3'd5: m_data = m_data & ~bus.writedata[9:0];
                    default: ;
                endcase
            end
        end
    end
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_out_port", {22'd0, out_port}, {22'd0, m_data ^ (m_mask & {10{ph(n)}})});
            check("model_readdata", bus.readdata, m_rd);
        end
    end
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask
    task automatic rd(input logic [2:0] a);
        bus.address = a;
        @(negedge clk);
    endtask
    initial begin
        bit found;
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (2) @(negedge clk);
        check("reset_out_port", {22'd0, out_port}, 32'h2A);
        check("reset_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
        rd(3'd0);
        check("reset_readback", bus.readdata, 32'h2A);
        wr(3'd0, 32'h0F0);
        check("data_write", {22'd0, out_port}, 32'h0F0);
        wr(3'd4, 32'h003);
        check("outset", {22'd0, out_port}, 32'h0F3);
        wr(3'd5, 32'h010);
        check("outclr", {22'd0, out_port}, 32'h0E3);
        rd(3'd0);
        check("data_readback", bus.readdata, 32'h0E3);
        rd(3'd4); check("read_outset", bus.readdata, 32'h0);
        rd(3'd5); check("read_outclr", bus.readdata, 32'h0);
        rd(3'd7); check("read_unmapped", bus.readdata, 32'h0);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd0);
        check("unmapped_write_ignored", bus.readdata, 32'h0E3);
        wr(3'd0, 32'hFFFF_FFFF);
        check("read_during_write", bus.readdata, 32'h0E3);
        check("wide_write_out", {22'd0, out_port}, 32'h3FF);
        rd(3'd0);
        check("wide_write_readback", bus.readdata, 32'h3FF);
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h001);
        wr(3'd2, 32'h3);
        bus.address = 3'd3;
        repeat (3) begin
            @(negedge clk);
            check("div3_before_toggle", {22'd0, out_port}, 32'h0);
        end
        @(negedge clk);
        check("div3_first_toggle", {22'd0, out_port}, 32'h001);
        @(negedge clk);
        check("div3_status", bus.readdata, 32'h1);
        repeat (3) @(negedge clk);
        check("div3_second_toggle", {22'd0, out_port}, 32'h0);
        wr(3'd1, 32'h300);
        wr(3'd2, 32'h0);
        check("div0_start", {22'd0, out_port}, 32'h0);
        @(negedge clk);
        check("div0_toggle_a", {22'd0, out_port}, 32'h300);
        @(negedge clk);
        check("div0_toggle_b", {22'd0, out_port}, 32'h0);
        wr(3'd2, 32'h5);
        check("div_rewrite_clear", {22'd0, out_port}, 32'h0);
        repeat (5) @(negedge clk);
        check("div5_hold", {22'd0, out_port}, 32'h0);
        @(negedge clk);
        check("div5_toggle", {22'd0, out_port}, 32'h300);
        wr(3'd1, 32'h3FF);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ph(n)) found = 1;
            else @(negedge clk);
        end
        check("phase_one_reached", {31'd0, found}, 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midblink_reset_out", {22'd0, out_port}, 32'h2A);
        rd(3'd1); check("midblink_mask", bus.readdata, 32'h0);
        rd(3'd2); check("midblink_div", bus.readdata, 32'h0);
        repeat (5) begin
            @(negedge clk);
            check("midblink_no_toggle", {22'd0, out_port}, 32'h2A);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/nios_system_tec1_led_pio.md
Name: nios_system_tec1_led_pio

Overview:
- Avalon-MM slave output port driving a DATA_WIDTH-bit LED bank from the Nios II system.
- It is the write-direction counterpart of the switch input port.
- Holds a software-written output register with atomic bit set and clear, plus a hardware blink engine. The engine toggles selected bits at a programmable period without CPU involvement.
- Sits on the system interconnect beside the other PIO slaves; out_port goes to the board LEDs.

Parameters:
- DATA_WIDTH, 10, width of out_port and of the DATA/MASK registers.
- RESET_VALUE, 0, value of the DATA register after reset.
- DIV_WIDTH, 24, width of the blink period register and its counter.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- address  input  3  word address of the register.
- chipselect  input  1  slave select; writes take effect only when this is 1.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above the register width are ignored.
- readdata  output  32  registered read data; unused upper bits are 0.
- out_port  output  DATA_WIDTH  LED drive.

Behaviour:
- Register map:
  - 0 DATA: R/W.
  - 1 MASK: R/W, selects which bits blink.
  - 2 DIV: R/W, DIV_WIDTH bits, blink half-period minus 1.
  - 3 STATUS: RO, bit0 = phase.
  - 4 OUTSET: WO; DATA <= DATA | wd.
  - 5 OUTCLR: WO; DATA <= DATA & ~wd.
  - 6 and 7 unmapped: writes are ignored, reads return 0.
  - Reads of 4 and 5 return 0.
- Write: occurs when chipselect=1 and write_n=0 on a rising edge. The new value is visible in the register and in out_port on the next cycle.
- Read path:
  - readdata <= zero-extended mux(address) on every clock edge, independent of chipselect. Latency is 1 cycle.
  - When a read and a write to the same address happen in the same cycle, readdata returns the pre-write value.
- Output: out_port = DATA ^ (MASK & {DATA_WIDTH{phase}}). This is combinational from registers, so no extra flop.
- Blink engine:
  - cnt is DIV_WIDTH bits.
  - Each cycle: if cnt == DIV, then cnt <= 0 and phase <= ~phase; else cnt <= cnt+1.
  - With DIV=0, phase toggles every cycle.
  - The engine runs continuously, including when MASK=0.
  - Writing DIV clears cnt and phase to 0 on the same edge. The write takes priority over a simultaneous terminal count.
  - Writing MASK does not affect cnt or phase.
  - Writing DIV to a value below the current cnt cannot occur, because the DIV write clears cnt.
- Reset (reset_n=0 at an edge):
  - DATA=RESET_VALUE, MASK=0, DIV=0, cnt=0, phase=0, readdata=0.
  - As a result, out_port=RESET_VALUE.
  - Reset mid-blink immediately forces all of the above on the next edge.
  - While reset is held, writes are ignored.

Test Plan:
- Reset behaviour: hold reset_n=0 for 2 clocks with RESET_VALUE=10'h2A -> out_port=10'h2A, readdata=0. Read address 0 after release -> readdata=32'h2A one cycle later.
- Set and clear: write DATA=10'h0F0, then OUTSET 10'h003, then OUTCLR 10'h010 -> out_port sequence is 0F0, 0F3, 0E3. Readback of address 0 = 32'h0E3. Reads of addresses 4, 5 and 7 return 0. Writes to addresses 6 and 7 change nothing.
- Width handling and read-during-write: write writedata=32'hFFFF_FFFF to DATA -> DATA=10'h3FF and the readback upper 22 bits are 0. Read address 0 in the same cycle as the write -> readdata shows the old value.
- Blink at DIV=3: write DATA=0, MASK=10'h001, DIV=3 -> out_port[0] toggles every 4 cycles, first toggle 4 cycles after the DIV write. Other bits stay 0. STATUS bit0 tracks the phase.
- Blink at DIV=0 and DIV rewrite: with MASK=10'h300 and DIV=0 -> bits 9:8 toggle every cycle. Rewrite DIV=5 in the cycle where the terminal count would fire -> cnt and phase go to 0, then the next toggle comes 6 cycles later.
- Reset mid-blink: with phase=1 and MASK=10'h3FF, pulse reset_n low for 1 cycle -> out_port=RESET_VALUE, MASK=0 and DIV=0 on readback, and no further toggling.
